// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: priority arbiter that plays one of four short melodies
// on a shared square-wave buzzer, with preemption by higher-priority ids.
module buzzer_arbiter #(
    parameter int unsigned NOTE_CYCLES = 5_000_000,
    parameter int unsigned T_DO        = 95_566,
    parameter int unsigned T_MI        = 75_843,
    parameter int unsigned T_SOL       = 63_776,
    parameter int unsigned T_SI        = 50_619
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       mute,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] active_id
);

    function automatic int unsigned max2(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned TMAX =
        max2(max2(T_DO, T_MI), max2(T_SOL, T_SI));
    localparam int unsigned TW = $clog2(TMAX + 1);
    localparam int unsigned NW = $clog2(NOTE_CYCLES + 1);

    localparam logic [TW-1:0] P_DO  = TW'(T_DO);
    localparam logic [TW-1:0] P_MI  = TW'(T_MI);
    localparam logic [TW-1:0] P_SOL = TW'(T_SOL);
    localparam logic [TW-1:0] P_SI  = TW'(T_SI);
    localparam logic [NW-1:0] N_END = NW'(NOTE_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_PLAY
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    pend_q, pend_d;
    logic [1:0]    id_q, id_d;
    logic [1:0]    note_q, note_d;
    logic [TW-1:0] tone_q, tone_d;
    logic [NW-1:0] timer_q, timer_d;
    logic          level_q, level_d;
    logic          buzzer_q, buzzer_d;

    logic [1:0]    sel;
    logic [3:0]    clr;
    logic          higher;
    logic          start;
    logic [TW-1:0] cur_t;
    logic          cur_rest;

    // Highest pending index, and whether it outranks the active melody.
    always_comb begin
        sel = 2'd0;
        if (pend_q[3]) begin
            sel = 2'd3;
        end else if (pend_q[2]) begin
            sel = 2'd2;
        end else if (pend_q[1]) begin
            sel = 2'd1;
        end
        higher = |(pend_q & (4'b1110 << id_q));
    end

    // Melody table: half-period and rest flag of the current note.
    always_comb begin
        cur_t    = P_SI;
        cur_rest = 1'b0;
        case (id_q)
            2'd0: cur_t = P_SI;
            2'd1: cur_t = (note_q == 2'd0) ? P_DO : P_MI;
            2'd2: begin
                if (note_q == 2'd0) begin
                    cur_t = P_DO;
                end else if (note_q == 2'd1) begin
                    cur_t = P_MI;
                end else begin
                    cur_t = P_SOL;
                end
            end
            default: begin
                cur_t    = P_SI;
                cur_rest = note_q[0];
            end
        endcase
    end

    // Next state: selection/preemption first, then note and tone timing.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        note_d  = note_q;
        tone_d  = tone_q;
        timer_d = timer_q;
        level_d = level_q;
        clr     = 4'b0000;
        start   = 1'b0;

        if (state_q == S_IDLE) begin
            start = |pend_q;
        end else begin
            start = higher;
        end

        if (start) begin
            state_d  = S_PLAY;
            id_d     = sel;
            clr[sel] = 1'b1;
            note_d   = 2'd0;
            tone_d   = '0;
            timer_d  = '0;
            level_d  = 1'b0;
        end else if (state_q == S_PLAY) begin
            if (timer_q == N_END) begin
                timer_d = '0;
                tone_d  = '0;
                level_d = 1'b0;
                if (note_q == id_q) begin
                    // Melody length is id+1 notes, so note==id is the last.
                    state_d = S_IDLE;
                    id_d    = 2'd0;
                    note_d  = 2'd0;
                end else begin
                    note_d = note_q + 2'd1;
                end
            end else begin
                timer_d = timer_q + 1'b1;
                if (tone_q == cur_t - TW'(1)) begin
                    tone_d  = '0;
                    level_d = cur_rest ? 1'b0 : ~level_q;
                end else begin
                    tone_d = tone_q + 1'b1;
                end
            end
        end

        // A request on the selecting edge re-arms its bit.
        pend_d   = (pend_q & ~clr) | req;
        buzzer_d = level_d & ~mute;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            pend_q   <= 4'b0000;
            id_q     <= 2'd0;
            note_q   <= 2'd0;
            tone_q   <= '0;
            timer_q  <= '0;
            level_q  <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            id_q     <= id_d;
            note_q   <= note_d;
            tone_q   <= tone_d;
            timer_q  <= timer_d;
            level_q  <= level_d;
            buzzer_q <= buzzer_d;
        end
    end

    assign buzzer    = buzzer_q;
    assign busy      = (state_q == S_PLAY);
    assign active_id = id_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb_buzzer_arbiter: directed and random requests checked every cycle
// against an arithmetic model of melody timing and priority.
module tb_buzzer_arbiter;

    localparam int NC = 20;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       mute;
    logic       buzzer;
    logic       busy;
    logic [1:0] active_id;

    int n_checks;
    int n_fail;

    bit [3:0] m_pend;
    bit       m_busy;
    int       m_id;
    int       m_el;
    bit       m_buz;

    buzzer_arbiter #(
        .NOTE_CYCLES(NC),
        .T_DO(2),
        .T_MI(3),
        .T_SOL(4),
        .T_SI(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .mute(mute),
        .buzzer(buzzer),
        .busy(busy),
        .active_id(active_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Half-period of note n of melody id; 0 marks a rest.
    function automatic int tone(input int id, input int n);
        case (id)
            0: return 5;
            1: return (n == 0) ? 2 : 3;
            2: return (n == 0) ? 2 : ((n == 1) ? 3 : 4);
            default: return (n % 2 == 0) ? 5 : 0;
        endcase
    endfunction

    function automatic int hi_idx(input bit [3:0] p);
        for (int i = 3; i >= 0; i--) begin
            if (p[i]) return i;
        end
        return 0;
    endfunction

    function automatic bit level(input int id, input int el);
        int n;
        int t;
        int tt;
        n  = el / NC;
        t  = el % NC;
        tt = tone(id, n);
        if (tt == 0) return 1'b0;
        return ((t / tt) % 2) == 1;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_busy = 1'b0;
        m_id   = 0;
        m_el   = 0;
        m_buz  = 1'b0;
    endtask

    task automatic model_edge(input bit [3:0] r, input bit mu);
        bit [3:0] op;
        bit [3:0] clr;
        bit       go;
        op  = m_pend;
        clr = '0;
        go  = 1'b0;
        if (m_busy) begin
            m_el++;
            if (op != 0 && hi_idx(op) > m_id) begin
                go = 1'b1;
            end else if (m_el == (m_id + 1) * NC) begin
                m_busy = 1'b0;
                m_id   = 0;
                m_el   = 0;
            end
        end else if (op != 0) begin
            go = 1'b1;
        end
        if (go) begin
            m_id      = hi_idx(op);
            clr[m_id] = 1'b1;
            m_busy    = 1'b1;
            m_el      = 0;
        end
        m_pend = (op & ~clr) | r;
        m_buz  = m_busy && level(m_id, m_el) && !mu;
    endtask

    task automatic cycle(input logic [3:0] r, input logic mu);
        req  = r;
        mute = mu;
        @(posedge clk);
        model_edge(r, mu);
        #1;
        check("busy", 32'(busy), 32'(m_busy));
        check("active_id", 32'(active_id), 32'(m_id));
        check("buzzer", 32'(buzzer), 32'(m_buz));
    endtask

    task automatic idle(input int n, input logic mu);
        for (int i = 0; i < n; i++) cycle(4'b0000, mu);
    endtask

    task automatic mid_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_id", 32'(active_id), 32'd0);
        check("rst_buzzer", 32'(buzzer), 32'd0);
        #3;
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        logic       mu;
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b0;
        req  = 4'b0000;
        mute = 1'b0;
        model_reset();
        #3;
        check("init_busy", 32'(busy), 32'd0);
        check("init_id", 32'(active_id), 32'd0);
        check("init_buzzer", 32'(buzzer), 32'd0);
        #9;
        rst = 1'b1;

        // click melody, then feed, then play
        cycle(4'b0001, 1'b0);
        idle(30, 1'b0);
        cycle(4'b0100, 1'b0);
        idle(70, 1'b0);

        // feed preempted by alarm five cycles later
        cycle(4'b0010, 1'b0);
        idle(4, 1'b0);
        cycle(4'b1000, 1'b0);
        idle(90, 1'b0);

        // simultaneous click and play
        cycle(4'b0101, 1'b0);
        idle(90, 1'b0);

        // muted alarm
        cycle(4'b1000, 1'b1);
        idle(90, 1'b1);

        // reset mid-note with feed pending, then quiet
        cycle(4'b0010, 1'b0);
        idle(3, 1'b0);
        cycle(4'b0010, 1'b0);
        idle(5, 1'b0);
        mid_reset();
        idle(60, 1'b0);

        // first edge after release accepts a request
        mid_reset();
        cycle(4'b0001, 1'b0);
        idle(25, 1'b0);

        // re-request of the active id replays it
        cycle(4'b0100, 1'b0);
        idle(10, 1'b0);
        cycle(4'b0100, 1'b0);
        idle(130, 1'b0);

        // random traffic with occasional mute toggles
        mu = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 4; b++) begin
                r[b] = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 49) == 0) mu = ~mu;
            cycle(r, mu);
            if ($urandom_range(0, 999) == 0) mid_reset();
        end
        idle(100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/buzzer_arbiter.md
BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 Parameter NOTE_CYCLES, default 5_000_000: duration of one melody note in clk cycles (100 ms at 50 MHz).
REQ-002 Parameters T_DO, T_MI, T_SOL, T_SI, defaults 95_566, 75_843, 63_776, 50_619: tone half-periods in clk cycles; each is ≥2.
REQ-003 clk  input  1  system clock (50 MHz); all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 req  input  4  sound request pulses: [0] joystick click, [1] feed, [2] play, [3] alarm; bit 3 has the highest priority.
REQ-006 mute  input  1  1 forces buzzer low; sequencing continues unchanged.
REQ-007 buzzer  output  1  square-wave drive to the shared buzzer.
REQ-008 busy  output  1  1 while a melody is playing.
REQ-009 active_id  output  2  index of the melody playing; 0 when idle.

Function
REQ-010 Request latching: each req bit high at a rising edge sets the matching pending bit at that edge; pulses of any length are accepted.
REQ-011 Melody table, as ordered notes, with length in notes:
  - id0: SI (length 1)
  - id1: DO, MI (length 2)
  - id2: DO, MI, SOL (length 3)
  - id3: SI, REST, SI, REST (length 4)
REQ-012 FSM states: IDLE and PLAY.
REQ-013 IDLE with pending≠0 at an edge: that edge selects the highest set pending index, clears its pending bit, sets active_id, and enters PLAY. It also sets note index 0, tone counter 0, note timer 0 and tone level 0.
REQ-014 Latency: a request pulse sampled at edge N in IDLE gives busy=1 after edge N+1.
REQ-015 Tone generation in PLAY:
  - The tone counter counts 0..T−1, where T is the current note's half-period.
  - On the edge where the counter equals T−1, the counter wraps to 0 and the tone level toggles.
  - The first high level therefore starts T cycles after note start.
REQ-016 REST notes hold the tone level at 0; the counter still runs.
REQ-017 Note timer: counts 0..NOTE_CYCLES−1 in PLAY. At terminal count:
  - If note index = length−1: enter IDLE; busy=0, active_id=0, tone level 0.
  - Otherwise: increment note index, reset tone counter and tone level to 0, reset the timer.
REQ-018 Preemption: in PLAY, if pending holds any index greater than active_id, the current melody is aborted and discarded (never resumed). On that edge the selection of REQ-013 is performed directly, with no IDLE cycle.
REQ-019 Preemption has precedence over a note-end or melody-end transition occurring on the same edge.
REQ-020 Equal or lower-priority requests arriving during PLAY stay pending and are served, highest first, after the current melody ends.
  - A re-request of the active id replays that melody afterwards.
REQ-021 Simultaneous set and clear: if a req bit is high on the same edge its pending bit is cleared by selection, the bit stays set (set wins).
REQ-022 buzzer = tone level AND NOT mute, registered; buzzer is 0 in IDLE.
REQ-023 Counter widths are sized to hold max(T_*) and NOTE_CYCLES without overflow; counters never wrap except as specified above.

Reset
REQ-024 rst=0 asynchronously forces: state IDLE, pending=0, buzzer=0, busy=0, active_id=0, all counters 0.
REQ-025 Reset asserted mid-melody aborts it and discards all pending requests.
REQ-026 The first request is accepted at the first rising edge after rst returns to 1.

Verification (NOTE_CYCLES=20, T_DO=2, T_MI=3, T_SOL=4, T_SI=5)
REQ-027 Case 1: req[0] one-cycle pulse at edge N. Required: busy=1 after N+1; buzzer rises after N+6 and toggles every 5 cycles; busy=0 and buzzer=0 after N+21.
REQ-028 Case 2: req[2] pulse. Required: buzzer half-periods are 2, then 3, then 4 cycles in consecutive 20-cycle windows; busy is high for 60 cycles total.
REQ-029 Case 3: req[1] pulse; req[3] pulse 5 cycles later. Required: on the edge after req[3] is latched, active_id=3 and tone counter=0; melody 1 never resumes; busy drops after 80 alarm cycles.
REQ-030 Case 4: req[0] and req[2] pulsed on the same edge. Required: id2 plays first, then id0 starts on the edge immediately following id2's last note, with no IDLE cycle observable beyond one edge.
REQ-031 Case 5: mute=1 throughout req[3]. Required: buzzer stays 0 while busy and active_id sequence normally.
REQ-032 Case 6: rst=0 mid-note with req[1] pending. Required: all outputs 0 immediately (no clock edge needed); no melody plays after rst is released.
